dmem_wbuf_bridge: RTL and testbench
===================================

DMEM_WBUF_BRIDGE -- requirements
Module: dmem_wbuf_bridge

Interface
REQ-001 Parameter DEPTH, default 4: write-buffer entries, power of two, 2..16.
REQ-002 Parameter AW, default 7: word-address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 CEN  input  1  core chip enable, active-low; not used in access decode.
REQ-007 WEN  input  1  core write strobe, active-low.
REQ-008 OEN  input  1  core read strobe, active-low.
REQ-009 A  input  AW  core word address.
REQ-010 Data2Mem  input  DW  core write data.
REQ-011 ReadDataMem  output  DW  read data returned to the core.
REQ-012 stall  output  1  core must hold all inputs stable while high.
REQ-013 mem_req  output  1  backing-memory request, held until acknowledged.
REQ-014 mem_we  output  1  1 = write request, 0 = read request.
REQ-015 mem_addr  output  AW  backing-memory address.
REQ-016 mem_wdata  output  DW  backing-memory write data.
REQ-017 mem_ack  input  1  one-cycle acknowledge from backing memory.
REQ-018 mem_rdata  input  DW  read data, valid in the mem_ack cycle.

Function
REQ-019 Decode: write when WEN=0; read when OEN=0 and WEN=1; otherwise idle.
REQ-020 Write with count<DEPTH: stall=0 combinationally; {A,Data2Mem} enqueued at the edge.
REQ-021 Write with count==DEPTH (registered count): stall=1 and no enqueue, even if a pop occurs in the same cycle.
REQ-022 Drain FSM states: IDLE, WR_REQ, RD_REQ, RD_DONE.
REQ-023 IDLE->WR_REQ when the buffer is non-empty; IDLE->RD_REQ when the buffer is empty and a read misses (REQ-027).
REQ-024 WR_REQ: mem_req=1, mem_we=1, mem_addr/mem_wdata=head entry; on mem_ack, pop head and go to IDLE.
REQ-025 RD_REQ: mem_req=1, mem_we=0, mem_addr=A; on mem_ack, capture mem_rdata into rdata_q and go to RD_DONE.
REQ-026 RD_DONE: ReadDataMem=rdata_q, stall=0 for exactly one cycle; then go to IDLE.
REQ-027 A read misses when no buffered entry matches A, or when forwarding is compiled out (REQ-036). A missed read holds stall=1 from detection until RD_DONE.
REQ-028 The buffer drains strictly in FIFO order. Head/tail pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
REQ-029 Simultaneous enqueue and pop with 0<count<DEPTH: count unchanged, both take effect.
REQ-030 mem_ack while mem_req=0 is ignored. mem_req never deasserts before mem_ack.
REQ-031 ReadDataMem=0 whenever no read is returning data. Outputs carry no X when inputs are known.

Reset
REQ-032 rst_n low immediately forces: FSM=IDLE, count=0, pointers=0, rdata_q=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, ReadDataMem=0.
REQ-033 Reset during an outstanding request drops mem_req immediately. Buffered writes are discarded.
REQ-034 Release of rst_n takes effect at the first rising clk edge after deassertion.

Configuration
REQ-035 Macro DMEM_WBUF_FWD_EN.
REQ-036 Defined: a read hit returns the youngest matching buffered data combinationally with stall=0. Undefined: every read is a miss and waits for an empty buffer plus the memory round trip.

Verification
REQ-037 Reset, then one write A=5, D=0xDEADBEEF, with mem_ack 2 cycles after mem_req -> stall=0 at issue; mem_req/mem_we=1, mem_addr=5, mem_wdata=0xDEADBEEF until ack; count returns to 0.
REQ-038 Five back-to-back writes, DEPTH=4, mem_ack held low -> 5th write sees stall=1. After the first ack, the 5th enqueues. Drain order matches issue order.
REQ-039 Write A=9 D=0x11, write A=9 D=0x22, then read A=9 with DMEM_WBUF_FWD_EN -> ReadDataMem=0x22 same cycle, stall=0. Without the macro -> stall until drain, then mem_addr=9 read.
REQ-040 Read A=3 on an empty buffer, mem_rdata=0xCAFE0001 with ack 3 cycles later -> stall=1 for 4 cycles; RD_DONE cycle shows ReadDataMem=0xCAFE0001, stall=0.
REQ-041 Assert rst_n=0 mid-WR_REQ with 3 entries queued -> mem_req=0 same cycle, count=0. Stray mem_ack after reset causes no pop.
REQ-042 Enqueue and pop in the same cycle at count=2 -> count stays 2, pointers advance, wrap verified over 10 operations.

Source files
------------

// File: rtl/dmem_wbuf_bridge.sv
// dmem_wbuf_bridge: posted-write FIFO between a core data port and a req/ack backing memory.
// Read forwarding from the buffer is enabled by defining DMEM_WBUF_FWD_EN.
module dmem_wbuf_bridge #(
  parameter int DEPTH = 4,
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  output logic [DW-1:0] ReadDataMem,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] buf_addr_q [DEPTH];
  logic [DW-1:0] buf_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] rdata_q, rdata_d, fwd_data;
  logic wr, rd, full, enq, pop, hit, unused_cen;
  assign unused_cen = CEN;
  assign wr = !WEN;
  assign rd = !OEN && WEN;
  assign full = count_q == CW'(DEPTH);
  assign enq = wr && !full;
  assign pop = state_q == WR_REQ && mem_ack;
`ifdef DMEM_WBUF_FWD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && buf_addr_q[head_q + PW'(i)] == A) begin
        hit = 1'b1;
        fwd_data = buf_data_q[head_q + PW'(i)];
      end
    end
  end
`else
  assign hit = 1'b0;
  assign fwd_data = '0;
`endif
  assign head_d = head_q + PW'(pop);
  assign tail_d = tail_q + PW'(enq);
  assign count_d = count_q + CW'(enq) - CW'(pop);
  assign rdata_d = (state_q == RD_REQ && mem_ack) ? mem_rdata : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr_q[tail_q] <= A;
      buf_data_q[tail_q] <= Data2Mem;
    end
  end
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: state_d = count_q != '0 ? WR_REQ : (rd && !hit) ? RD_REQ : IDLE;
      WR_REQ: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = buf_addr_q[head_q];
        mem_wdata = buf_data_q[head_q];
        state_d = mem_ack ? IDLE : WR_REQ;
      end
      RD_REQ: begin
        mem_req = 1'b1;
        mem_addr = A;
        state_d = mem_ack ? RD_DONE : RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  // Stall is combinational from decode, so it must be masked while reset is held.
  assign stall = rst_n && ((wr && full) || (rd && !hit && state_q != RD_DONE));
  assign ReadDataMem = state_q == RD_DONE ? rdata_q : (rd && hit) ? fwd_data : '0;
endmodule

// File: tb/tb_dmem_wbuf_bridge.sv
// tb_dmem_wbuf_bridge: directed and random checks of the write-buffer bridge against a queue model.
module tb_dmem_wbuf_bridge;
  localparam int DEPTH = 4;
  typedef struct packed {logic [6:0] a; logic [31:0] d;} ent_t;
  logic clk = 0, rst_n = 0, CEN = 0, WEN = 1, OEN = 1, mem_ack = 0;
  logic [6:0] A = 0;
  logic [31:0] Data2Mem = 0, mem_rdata = 0;
  logic [31:0] ReadDataMem, mem_wdata;
  logic [6:0] mem_addr;
  logic stall, mem_req, mem_we;
  int total = 0, bad = 0;
  ent_t q[$], iss[$];
  int phase = 0;
  logic [31:0] rdv = 0;
  logic last_stall = 0;
  logic s_stall, s_req, s_we;
  logic [31:0] s_addr, s_wdata, s_rdm;

  dmem_wbuf_bridge dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic wen, input logic oen, input logic [6:0] a, input logic [31:0] d, input logic ack);
    WEN = wen; OEN = oen; A = a; Data2Mem = d; mem_ack = ack;
  endtask

  // One clock: compare at negedge, then advance the model at the rising edge.
  task automatic step();
    logic wr, rd, hit, e_stall, e_req, e_we;
    logic [31:0] hd, e_addr, e_wdata, e_rdm;
    int n;
    ent_t e;
    @(negedge clk);
    wr = !WEN;
    rd = !OEN && WEN;
    hit = 0;
    hd = 0;
`ifdef DMEM_WBUF_FWD_EN
    foreach (q[i]) if (q[i].a == A) begin hit = 1; hd = q[i].d; end
`endif
    e_req = phase == 1 || phase == 2;
    e_we = phase == 1;
    e_addr = (phase == 1 && q.size() > 0) ? 32'(q[0].a) : phase == 2 ? 32'(A) : 0;
    e_wdata = (phase == 1 && q.size() > 0) ? q[0].d : 0;
    e_stall = wr ? (q.size() == DEPTH) : rd ? (!hit && phase != 3) : 0;
    e_rdm = phase == 3 ? rdv : (rd && hit) ? hd : 0;
    s_stall = stall; s_req = mem_req; s_we = mem_we;
    s_addr = 32'(mem_addr); s_wdata = mem_wdata; s_rdm = ReadDataMem;
    chk("stall", 32'(s_stall), 32'(e_stall));
    chk("mem_req", 32'(s_req), 32'(e_req));
    chk("mem_we", 32'(s_we), 32'(e_we));
    chk("mem_addr", s_addr, e_addr);
    chk("mem_wdata", s_wdata, e_wdata);
    chk("ReadDataMem", s_rdm, e_rdm);
    if (s_req && s_we && mem_ack) begin
      if (iss.size() == 0) chk("drain_extra", 1, 0);
      else begin
        e = iss.pop_front();
        chk("drain_addr", s_addr, 32'(e.a));
        chk("drain_data", s_wdata, e.d);
      end
    end
    @(posedge clk);
    n = q.size();
    if (phase == 1 && mem_ack) void'(q.pop_front());
    if (wr && n < DEPTH) begin q.push_back({A, Data2Mem}); iss.push_back({A, Data2Mem}); end
    case (phase)
      0: phase = n != 0 ? 1 : (rd && !hit) ? 2 : 0;
      1: if (mem_ack) phase = 0;
      2: if (mem_ack) begin rdv = mem_rdata; phase = 3; end
      default: phase = 0;
    endcase
    last_stall = e_stall;
    #1;
  endtask

  task automatic drain();
    int k;
    set_in(1, 1, 0, 0, 1);
    for (k = 0; k < 40 && (q.size() != 0 || phase != 0); k++) step();
    chk("drain_timeout", 32'(q.size() != 0 || phase != 0), 0);
    mem_ack = 0;
  endtask

  initial begin
    int k;
    logic [3:0] r;
    OEN = 0;
    #3;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdm", ReadDataMem, 0);
    OEN = 1;
    #9 rst_n = 1;
    @(posedge clk); #1;

    set_in(0, 1, 5, 32'hDEADBEEF, 0); step();
    chk("w5_issue_stall", 32'(s_stall), 0);
    set_in(1, 1, 0, 0, 0); step();
    step();
    chk("w5_req", 32'(s_req), 1);
    chk("w5_we", 32'(s_we), 1);
    chk("w5_addr", s_addr, 5);
    chk("w5_data", s_wdata, 32'hDEADBEEF);
    step();
    mem_ack = 1; step();
    chk("w5_ack_req", 32'(s_req), 1);
    mem_ack = 0; step();
    chk("w5_done_req", 32'(s_req), 0);
    step();
    chk("w5_empty_req", 32'(s_req), 0);

    drain();
    mem_rdata = 32'hCAFE0001;
    for (int c = 0; c < 4; c++) begin
      set_in(1, 0, 3, 0, c == 3); step();
      chk("rd3_stall", 32'(s_stall), 1);
    end
    mem_ack = 0; step();
    chk("rd3_done_stall", 32'(s_stall), 0);
    chk("rd3_done_data", s_rdm, 32'hCAFE0001);
    set_in(1, 1, 0, 0, 0); step();
    chk("rd3_after_data", s_rdm, 0);

    drain();
    set_in(0, 1, 9, 32'h11, 0); step();
    set_in(0, 1, 9, 32'h22, 0); step();
    set_in(1, 0, 9, 0, 0); step();
`ifdef DMEM_WBUF_FWD_EN
    chk("fwd_data", s_rdm, 32'h22);
    chk("fwd_stall", 32'(s_stall), 0);
`else
    chk("nofwd_stall", 32'(s_stall), 1);
    mem_ack = 1; mem_rdata = 32'h5A5A0009;
    for (k = 0; k < 40 && last_stall; k++) begin
      step();
      if (s_req && !s_we) chk("nofwd_rd_addr", s_addr, 9);
    end
    chk("nofwd_timeout", 32'(last_stall), 0);
    chk("nofwd_rdata", s_rdm, 32'h5A5A0009);
`endif

    drain();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 7'(20 + i), $urandom, 0); step();
      chk("b2b_stall", 32'(s_stall), 0);
    end
    set_in(0, 1, 24, 32'h55, 0); step();
    chk("b2b_full_stall", 32'(s_stall), 1);
    mem_ack = 1;
    for (k = 0; k < 10 && last_stall; k++) step();
    chk("b2b_timeout", 32'(last_stall), 0);
    chk("b2b_enq_stall", 32'(s_stall), 0);
    drain();

    for (int i = 0; i < 3; i++) begin set_in(0, 1, 7'(40 + i), $urandom, 0); step(); end
    set_in(1, 1, 0, 0, 0); step();
    chk("pre_rst_req", 32'(s_req), 1);
    OEN = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_addr", 32'(mem_addr), 0);
    chk("arst_rdm", ReadDataMem, 0);
    q.delete(); iss.delete(); phase = 0; rdv = 0; last_stall = 0;
    set_in(1, 1, 0, 0, 1);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_ack_req", 32'(s_req), 0);
    end
    set_in(0, 1, 50, 32'h77, 0); step();
    drain();

    set_in(0, 1, 60, $urandom, 0); step();
    set_in(0, 1, 61, $urandom, 0); step();
    for (int i = 0; i < 20; i++) begin
      if (phase == 1) set_in(0, 1, 7'(62 + i), $urandom, 1);
      else set_in(1, 1, 0, 0, 0);
      step();
      chk("wrap_stall", 32'(s_stall), 0);
    end
    drain();

    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) begin
        r = 4'($urandom_range(0, 9));
        WEN = !(r < 4);
        OEN = r < 4 ? 1'($urandom_range(0, 1)) : !(r < 7);
        A = 7'($urandom_range(0, 15));
        Data2Mem = $urandom;
        CEN = 1'($urandom_range(0, 1));
      end
      mem_ack = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
      step();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
